// File: rtl/led_scanner.sv
// LED bank scanner: a lit position steps every COUNT enabled cycles (bounce, rotate or freeze).
// Optional comet tail via macro LED_SCANNER_TRAIL_EN (lights pos and the previous pos).
module led_scanner #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dataOut,
  output logic             dir,
  output logic             tick
);

  localparam int unsigned CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int unsigned PW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);
  localparam logic [PW-1:0] POS_MAX  = PW'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_BOUNCE  = 2'b00,
    MODE_ROT_LSB = 2'b01,
    MODE_ROT_MSB = 2'b10,
    MODE_FREEZE  = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             step_c;
  logic             bounce_dir_c;
`ifdef LED_SCANNER_TRAIL_EN
  logic [PW-1:0]    prev_q, prev_d;
`endif

  assign mode_s = mode_e'(mode);

  // Next-state: counter, step decision and position update
  always_comb begin
    cnt_d        = cnt_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    tick_d       = 1'b0;
    step_c       = en && (cnt_q == CNT_LAST);
    bounce_dir_c = dir_q;

    if (en) begin
      cnt_d = step_c ? '0 : cnt_q + CW'(1);
    end

    // At an end the bounce direction must point back into the bank
    if (pos_q == '0) begin
      bounce_dir_c = 1'b1;
    end else if (pos_q == POS_MAX) begin
      bounce_dir_c = 1'b0;
    end

    if (step_c) begin
      tick_d = 1'b1;
      case (mode_s)
        MODE_BOUNCE: begin
          pos_d = bounce_dir_c ? pos_q + PW'(1) : pos_q - PW'(1);
          dir_d = bounce_dir_c;
          if (pos_d == '0) begin
            dir_d = 1'b1;
          end else if (pos_d == POS_MAX) begin
            dir_d = 1'b0;
          end
        end
        MODE_ROT_LSB: begin
          dir_d = 1'b0;
          pos_d = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
        end
        MODE_ROT_MSB: begin
          dir_d = 1'b1;
          pos_d = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
        end
        MODE_FREEZE: begin
        end
      endcase
    end

`ifdef LED_SCANNER_TRAIL_EN
    prev_d = prev_q;
    if (step_c && (mode_s != MODE_FREEZE)) begin
      prev_d = pos_q;
    end
    data_d = (WIDTH'(1) << pos_d) | (WIDTH'(1) << prev_d);
`else
    data_d = WIDTH'(1) << pos_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pos_q  <= POS_MAX;
      dir_q  <= 1'b0;
      tick_q <= 1'b0;
      data_q <= WIDTH'(1) << POS_MAX;
`ifdef LED_SCANNER_TRAIL_EN
      prev_q <= POS_MAX;
`endif
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
      data_q <= data_d;
`ifdef LED_SCANNER_TRAIL_EN
      prev_q <= prev_d;
`endif
    end
  end

  assign dataOut = data_q;
  assign dir     = dir_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_led_scanner.sv
// Bench for led_scanner: directed vector table, corner sequences and random run against a step model.
// Two instances: WIDTH=8/COUNT=4 and WIDTH=5/COUNT=1; honours LED_SCANNER_TRAIL_EN.
module tb_led_scanner;

`ifdef LED_SCANNER_TRAIL_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] data_a;
  logic       dir_a, tick_a;
  logic [4:0] data_b;
  logic       dir_b, tick_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_scanner #(.WIDTH(8), .COUNT(4)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .dataOut(data_a), .dir(dir_a), .tick(tick_a)
  );

  led_scanner #(.WIDTH(5), .COUNT(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .dataOut(data_b), .dir(dir_b), .tick(tick_b)
  );

  typedef struct {
    int pos;
    int prev;
    int dir;
    int cnt;
    int tick;
  } m_t;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] d_plain;
    logic [7:0] d_trail;
    logic       dir;
  } vec_t;

  m_t   ma, mb;
  vec_t vecs[$];

  // Step-level behaviour: one call per clock edge with the inputs sampled on that edge
  function automatic m_t mnext(m_t s, int w, int count, logic r, logic e, logic [1:0] md);
    m_t n;
    int d;
    n = s;
    n.tick = 0;
    if (r) begin
      n.pos = w - 1; n.prev = w - 1; n.dir = 0; n.cnt = 0;
      return n;
    end
    if (!e) return n;
    if (s.cnt < count - 1) begin
      n.cnt = s.cnt + 1;
      return n;
    end
    n.cnt  = 0;
    n.tick = 1;
    case (md)
      2'b00: begin
        d = (s.pos == 0) ? 1 : (s.pos == w - 1) ? 0 : s.dir;
        n.pos  = s.pos + (d == 1 ? 1 : -1);
        n.dir  = (n.pos == 0) ? 1 : (n.pos == w - 1) ? 0 : d;
        n.prev = s.pos;
      end
      2'b01: begin n.pos = (s.pos + w - 1) % w; n.dir = 0; n.prev = s.pos; end
      2'b10: begin n.pos = (s.pos + 1) % w;     n.dir = 1; n.prev = s.pos; end
      default: ;
    endcase
    return n;
  endfunction

  function automatic int unsigned expd(m_t s);
    int unsigned v;
    v = 32'd1 << s.pos;
    if (TRAIL) v = v | (32'd1 << s.prev);
    return v;
  endfunction

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: advance both models, then compare every output of both instances
  task automatic cyc();
    ma = mnext(ma, 8, 4, rst, en, mode);
    mb = mnext(mb, 5, 1, rst, en, mode);
    @(posedge clk);
    #1;
    check("a_data", 32'(data_a), expd(ma));
    check("a_dir",  32'(dir_a),  32'(ma.dir));
    check("a_tick", 32'(tick_a), 32'(ma.tick));
    check("b_data", 32'(data_b), expd(mb));
    check("b_dir",  32'(dir_b),  32'(mb.dir));
    check("b_tick", 32'(tick_b), 32'(mb.tick));
  endtask

  task automatic add(input logic [1:0] md, input logic [7:0] dp, input logic [7:0] dt, input logic dr);
    vec_t v;
    v.mode = md; v.d_plain = dp; v.d_trail = dt; v.dir = dr;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] pick(input logic [7:0] dp, input logic [7:0] dt);
    return TRAIL ? dt : dp;
  endfunction

  initial begin
    int ticks;
    ma = '{pos: 7, prev: 7, dir: 0, cnt: 0, tick: 0};
    mb = '{pos: 4, prev: 4, dir: 0, cnt: 0, tick: 0};

    // Full bounce sweep, walk back to LSB, then both rotate wraps
    add(2'b00, 8'h40, 8'hC0, 1'b0); add(2'b00, 8'h20, 8'h60, 1'b0);
    add(2'b00, 8'h10, 8'h30, 1'b0); add(2'b00, 8'h08, 8'h18, 1'b0);
    add(2'b00, 8'h04, 8'h0C, 1'b0); add(2'b00, 8'h02, 8'h06, 1'b0);
    add(2'b00, 8'h01, 8'h03, 1'b1); add(2'b00, 8'h02, 8'h03, 1'b1);
    add(2'b00, 8'h04, 8'h06, 1'b1); add(2'b00, 8'h08, 8'h0C, 1'b1);
    add(2'b00, 8'h10, 8'h18, 1'b1); add(2'b00, 8'h20, 8'h30, 1'b1);
    add(2'b00, 8'h40, 8'h60, 1'b1); add(2'b00, 8'h80, 8'hC0, 1'b0);
    add(2'b00, 8'h40, 8'hC0, 1'b0); add(2'b00, 8'h20, 8'h60, 1'b0);
    add(2'b00, 8'h10, 8'h30, 1'b0); add(2'b00, 8'h08, 8'h18, 1'b0);
    add(2'b00, 8'h04, 8'h0C, 1'b0); add(2'b00, 8'h02, 8'h06, 1'b0);
    add(2'b00, 8'h01, 8'h03, 1'b1);
    add(2'b01, 8'h80, 8'h81, 1'b0);
    add(2'b10, 8'h01, 8'h81, 1'b1);

    rst = 1'b1; en = 1'b1; mode = 2'b00;
    cyc(); cyc();
    check("reset_data", 32'(data_a), 32'h80);
    check("reset_dir",  32'(dir_a),  32'h0);
    check("reset_tick", 32'(tick_a), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      repeat (4) cyc();
      check("vec_data", 32'(data_a), 32'(pick(vecs[i].d_plain, vecs[i].d_trail)));
      check("vec_dir",  32'(dir_a),  32'(vecs[i].dir));
      check("vec_tick", 32'(tick_a), 32'h1);
    end

    // Pause after two counted cycles; step lands two enabled cycles after resume
    mode = 2'b00;
    cyc(); cyc();
    en = 1'b0;
    repeat (10) begin
      cyc();
      check("pause_hold", 32'(data_a), 32'(pick(8'h01, 8'h81)));
    end
    en = 1'b1;
    cyc();
    check("pause_early", 32'(tick_a), 32'h0);
    cyc();
    check("pause_step_tick", 32'(tick_a), 32'h1);
    check("pause_step_data", 32'(data_a), 32'(pick(8'h02, 8'h03)));

    // Freeze at 0x10: output held, tick keeps its cadence
    repeat (12) cyc();
    check("pre_freeze", 32'(data_a), 32'(pick(8'h10, 8'h18)));
    mode = 2'b11;
    ticks = 0;
    repeat (20) begin
      cyc();
      if (tick_a) ticks++;
      check("freeze_hold", 32'(data_a), 32'(pick(8'h10, 8'h18)));
    end
    check("freeze_ticks", 32'(ticks), 32'd5);

    // Rotate up with wrap to 0x04 dir=1, then reset mid-period
    mode = 2'b10;
    repeat (24) cyc();
    check("pre_rst_data", 32'(data_a), 32'(pick(8'h04, 8'h06)));
    check("pre_rst_dir",  32'(dir_a),  32'h1);
    mode = 2'b00;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_data", 32'(data_a), 32'h80);
    check("mid_rst_dir",  32'(dir_a),  32'h0);
    check("mid_rst_tick", 32'(tick_a), 32'h0);
    repeat (3) cyc();
    check("post_rst_wait", 32'(data_a), 32'h80);
    cyc();
    check("post_rst_step", 32'(data_a), 32'(pick(8'h40, 8'hC0)));
    check("post_rst_tick", 32'(tick_a), 32'h1);

    // COUNT=1 instance: a step on every enabled cycle
    repeat (8) begin
      cyc();
      check("count1_tick", 32'(tick_b), 32'h1);
    end

    // Random inputs, checked each cycle by cyc()
    repeat (800) begin
      rst = ($urandom_range(0, 63) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
# led_scanner

Parametrised next-generation LED scanner for the lab board's LED bank. It drives a WIDTH-bit output with a lit position that steps once every COUNT clock cycles. The position either bounces between the two ends (Knight Rider sweep), rotates in either direction, or freezes. The block adds a pause input, a direction status output and a step strobe for downstream logic such as a sound or segment driver.

## Interface
- WIDTH, 8: number of LED outputs; must be ≥ 2.
- COUNT, 15: clock cycles per step; must be ≥ 1. Counter width is max(1, $clog2(COUNT)).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  count enable; low holds counter, position and direction.
- mode  in  2  00 bounce, 01 rotate toward LSB, 10 rotate toward MSB, 11 freeze.
- dataOut  out  WIDTH  LED pattern, registered.
- dir  out  1  current direction, registered: 0 toward LSB, 1 toward MSB.
- tick  out  1  registered one-cycle strobe, high in the cycle a step takes effect.

## Operation
- State:
  - pos: 0..WIDTH-1, where bit WIDTH-1 is the MSB.
  - dir.
  - counter.
  - prev_pos, used only when TRAIL is compiled in.
- Reset, on the rst edge, regardless of en and mode:
  - pos = WIDTH-1, prev_pos = WIDTH-1.
  - dir = 0, counter = 0, tick = 0.
  - dataOut = 1 << (WIDTH-1).
- Counting:
  - With en=1, counter increments each cycle.
  - When counter == COUNT-1, the edge performs a step, sets counter to 0 and registers tick=1.
  - With en=0, counter, pos, dir and prev_pos hold and tick=0.
- Step in mode 00 (bounce):
  - dir=0: pos decrements; if the new pos == 0, dir becomes 1 on the same edge.
  - dir=1: pos increments; if the new pos == WIDTH-1, dir becomes 0 on the same edge.
  - Each end position is therefore lit for exactly one step period, and the sweep period is 2·(WIDTH-1) steps.
- Step in mode 01: dir forced to 0; pos decrements, wrapping 0 → WIDTH-1.
- Step in mode 10: dir forced to 1; pos increments, wrapping WIDTH-1 → 0.
- Step in mode 11:
  - pos, dir and prev_pos unchanged.
  - Counter keeps running and tick still pulses.
- Mode changes:
  - Sampled only at the step edge; a change mid-period never causes an extra or early step.
  - On entering bounce from a rotate mode, the current dir is kept.
  - If pos is already at an end while entering bounce, dir is corrected toward the interior before the move. Example: pos=0, dir=0 gives pos=1, dir=1.
- On every step, prev_pos takes the old pos; in freeze mode it is unchanged.
- dataOut = one-hot(pos), registered alongside pos.

## Timing
- Step cadence: exactly every COUNT enabled cycles. With COUNT=1, a step occurs every enabled cycle.
- First step: the new dataOut is visible COUNT cycles after the first cycle with rst=0 and en=1.
- tick is high in the same cycle the new dataOut is first visible; it is never high for two consecutive cycles unless COUNT=1.
- Pausing: en low mid-period preserves the elapsed count. The remaining cycles complete after en returns high.
- rst mid-sweep: dataOut shows the MSB-only pattern in the cycle after the reset edge. Any pending step is discarded.
- No combinational path from inputs to outputs.

## Configuration
- LED_SCANNER_TRAIL_EN defined: dataOut = one-hot(pos) | one-hot(prev_pos), a two-LED comet tail.
  - After reset, and whenever pos == prev_pos, this collapses to a single bit.
  - At a bounce end the output is the two end bits.
- LED_SCANNER_TRAIL_EN undefined: prev_pos is not built and dataOut is strictly one-hot.

## Test plan
- Reset and sweep (WIDTH=8, COUNT=4, mode=00, en=1):
  - Immediately after reset: dataOut=0x80, dir=0.
  - Every 4 cycles: 0x40, 0x20, …, 0x01 (dir→1 on that edge), then 0x02, … back to 0x80 (dir→0).
  - tick pulses with each change.
- Rotate: reach 0x01, then set mode=01 → next step gives 0x80. Set mode=10 at 0x80 → next step gives 0x01, dir=1.
- Pause: drop en for 10 cycles after 2 counted cycles → no change during the pause. The step lands exactly 2 enabled cycles after en rises.
- Freeze: mode=11 at 0x10 for 20 cycles → dataOut stays 0x10 and tick pulses every 4 cycles.
- Reset mid-operation: assert rst for 1 cycle at 0x04 with dir=1 → 0x80, dir=0, tick=0. The counter restarts from 0.
- With LED_SCANNER_TRAIL_EN defined, bounce mode:
  - Sweep sequence: 0x80 → 0xC0 → 0x60 → … → 0x03 (pos 0) → 0x03 (pos 1) → 0x06.
  - With COUNT=1: one step per enabled cycle and tick constantly high.
